// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: datapath defaults,
// redirect-mode encoding and the fetch-ring entry layout.
package if_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int IALIGN_DEF = 4;

  localparam logic REDIR_REL = 1'b0;
  localparam logic REDIR_ABS = 1'b1;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// Reserved-slot ring: slots are reserved in issue order, filled in order, popped at head.
// Head is registered (visible the cycle after fill); caller gates reserve on used < DEPTH.
module fetch_ring
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      reserve_vld,
  input  logic [XLEN_DEF-1:0]       reserve_pc,
  input  logic                      fill_vld,
  input  logic [31:0]               fill_dat,
  input  logic                      pop,
  output fetch_entry_t              head,
  output logic [$clog2(DEPTH):0]    used
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fetch_entry_t slot_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  head_q, fill_q, tail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (clear) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i].filled <= 1'b0;
    end else begin
      if (reserve_vld) begin
        slot_q[tail_q[AW-1:0]].pc     <= reserve_pc;
        slot_q[tail_q[AW-1:0]].filled <= 1'b0;
        tail_q                        <= tail_q + PTR_ONE;
      end
      if (fill_vld) begin
        slot_q[fill_q[AW-1:0]].instr  <= fill_dat;
        slot_q[fill_q[AW-1:0]].filled <= 1'b1;
        fill_q                        <= fill_q + PTR_ONE;
      end
      if (pop) begin
        slot_q[head_q[AW-1:0]].filled <= 1'b0;
        head_q                        <= head_q + PTR_ONE;
      end
    end
  end

  assign head = slot_q[head_q[AW-1:0]];
  assign used = tail_q - head_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: owns the PC, issues in-order imem requests, buffers responses for decode.
// Decode sees a response one cycle after arrival; issue stops when the ring is fully reserved.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              FQ_DEPTH   = 4,
  parameter int              IALIGN     = IALIGN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic            redir_mode,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_offset,
  output logic            redir_misalign,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int              CW         = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FQ_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, target_sum, target;
  logic [CW-1:0]   outstanding_q, drop_cnt_q, used;
  logic            misalign_q, target_misaligned;
  logic            req_hs, rsp_drop, rsp_fill, pop;
  fetch_entry_t    head;

  assign target_sum        = redir_base + redir_offset;
  assign target            = (redir_mode == REDIR_ABS) ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign target_misaligned = |(target & ALIGN_MASK);

  assign imem_req_valid = !rst && (state_q == RUN) && !stall && !redir_valid && (used < DEPTH_C);
  assign req_hs         = imem_req_valid && imem_req_ready;
  // Responses owed to a flushed stream are consumed before any are kept.
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0) && !redir_valid;
  assign pop            = if_valid && if_ready && !redir_valid;

  always_comb begin
    state_d = state_q;
    if (redir_valid) state_d = target_misaligned ? HALT : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_ADDR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= redir_valid && target_misaligned;
      if (redir_valid) begin
        pc_q          <= target;
        drop_cnt_q    <= drop_cnt_q + outstanding_q - CW'(imem_rsp_valid);
        outstanding_q <= '0;
      end else begin
        if (req_hs) pc_q <= pc_q + PC_STEP;
        if (rsp_drop) drop_cnt_q <= drop_cnt_q - CW'(1);
        outstanding_q <= outstanding_q + CW'(req_hs) - CW'(rsp_fill);
      end
    end
  end

  fetch_ring #(.DEPTH(FQ_DEPTH)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (redir_valid),
    .reserve_vld (req_hs),
    .reserve_pc  (pc_q),
    .fill_vld    (rsp_fill),
    .fill_dat    (imem_rsp_data),
    .pop         (pop),
    .head        (head),
    .used        (used)
  );

  assign if_valid       = head.filled;
  assign if_pc          = head.pc;
  assign if_instr       = head.instr;
  assign imem_req_addr  = pc_q;
  assign redir_misalign = misalign_q;

endmodule
